// File: rtl/mod13_disp_pkg.sv
// Shared definitions for the mod-13 cascade display: active-low segment
// codes (gfedcba), the counter's legal maximum and the scan digit encodings.
package mod13_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Largest legal value of the upstream mod-13 counter.
  localparam logic [3:0] Q_MAX = 4'd12;

  // Scan position; also the bit position of the active-low anode select.
  typedef enum logic [1:0] {
    DIG_ONES = 2'd0,
    DIG_TENS = 2'd1,
    DIG_HI   = 2'd2
  } digit_e;

  // Scan order ones -> tens -> high digit -> ones.
  function automatic digit_e next_digit(input digit_e d);
    case (d)
      DIG_ONES: next_digit = DIG_TENS;
      DIG_TENS: next_digit = DIG_HI;
      default:  next_digit = DIG_ONES;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment decoder, active-low gfedcba.
// Dash has priority over blank; codes above 9 show a dash.
module seg7_decode
  import mod13_disp_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  // Priority: dash, then blank, then the numeric glyph.
  always_comb begin
    // NOTE: default assignment first so every path drives seg and no latch is inferred.
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      case (code)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/mod13_cascade_display.sv
// Downstream stage of the mod-13 up/down counter: cascaded high digit
// (mod HI_MOD) stepped by counter carries/borrows, and a 3-digit multiplexed
// common-anode display [2]=HI, [1]=Q tens, [0]=Q ones with registered outputs.
// Optional macro LEAD_ZERO_BLANK_EN blanks leading zeros on digits 2 and 1.
module mod13_cascade_display
  import mod13_disp_pkg::*;
#(
  parameter int HI_MOD   = 10,
  parameter int SCAN_DIV = 50000
) (
  input  logic                      CLK,
  input  logic                      nMR,
  input  logic [3:0]                Q,
  input  logic                      CO,
  input  logic                      EN,
  input  logic                      UpDown,
  output logic [$clog2(HI_MOD)-1:0] HI,
  output logic [2:0]                AN,
  output logic [6:0]                SEG
);

  localparam int HW = $clog2(HI_MOD);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [HW-1:0] HI_LAST  = HW'(HI_MOD - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] prescale;
  digit_e        idx;

  logic          q_valid;
  logic          tens;
  logic [3:0]    ones;

  logic [3:0]    dig_code;
  logic          dig_blank;
  logic          dig_dash;
  logic [2:0]    an_next;
  logic [6:0]    seg_next;

  // Cascaded high digit: one step per edge while the counter reports terminal count.
  always_ff @(posedge CLK or negedge nMR) begin
    if (!nMR) begin
      HI <= '0;
    end else if (EN && CO) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (UpDown) begin
        HI <= (HI == '0) ? HI_LAST : HI - 1'b1;
      end else begin
        HI <= (HI == HI_LAST) ? '0 : HI + 1'b1;
      end
    end
  end

  // Scan timing: each digit stays selected for SCAN_DIV cycles.
  always_ff @(posedge CLK or negedge nMR) begin
    if (!nMR) begin
      prescale <= '0;
      idx      <= DIG_ONES;
    end else if (prescale == PRE_LAST) begin
      prescale <= '0;
      idx      <= next_digit(idx);
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  // Split the counter value into tens/ones; 13..15 are flagged invalid.
  always_comb begin
    q_valid = (Q <= Q_MAX);
    tens    = 1'b0;
    ones    = Q;
    if (Q >= 4'd10) begin
      tens = 1'b1;
      ones = Q - 4'd10;
    end
  end

  // Select the code, blanking and anode pattern of the digit currently scanned.
  always_comb begin
    dig_code  = 4'd0;
    dig_blank = 1'b0;
    dig_dash  = 1'b0;
    an_next   = 3'b111;
    case (idx)
      DIG_ONES: begin
        an_next  = 3'b110;
        dig_code = ones;
        dig_dash = !q_valid;
      end
      DIG_TENS: begin
        an_next  = 3'b101;
        dig_code = {3'b000, tens};
        dig_dash = !q_valid;
`ifdef LEAD_ZERO_BLANK_EN
        dig_blank = (HI == '0) && !tens;
`endif
      end
      DIG_HI: begin
        an_next  = 3'b011;
        dig_code = 4'(HI);
`ifdef LEAD_ZERO_BLANK_EN
        dig_blank = (HI == '0);
`endif
      end
      default: begin
        dig_blank = 1'b1;
      end
    endcase
  end

  seg7_decode u_decode (
    .code  (dig_code),
    .blank (dig_blank),
    .dash  (dig_dash),
    .seg   (seg_next)
  );

  // Registered display outputs, one cycle behind the scan position.
  always_ff @(posedge CLK or negedge nMR) begin
    if (!nMR) begin
      AN  <= 3'b111;
      SEG <= SEG_BLANK;
    end else begin
      AN  <= an_next;
      SEG <= seg_next;
    end
  end

endmodule
